// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing monitor: rebuilds h/v counters from HSync/VSync and locks onto 640x480@60 timing.
// Optional macro VGA_RX_CRC_EN adds a per-frame CRC-16-CCITT over active pixels on output frame_crc.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic        HSync,
    input  logic        VSync,
    input  logic [7:0]  Red,
    input  logic [7:0]  Green,
    input  logic [7:0]  Blue,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic        de,
    output logic [23:0] pix_rgb,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt
`ifdef VGA_RX_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

    localparam logic [11:0] H_TOTAL_C     = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_C      = 12'(H_SYNC);
    localparam logic [10:0] H_ACT_START_C = 11'(H_ACT_START);
    localparam logic [10:0] H_ACT_END_C   = 11'(H_ACT_END);
    localparam logic [10:0] V_TOTAL_C     = 11'(V_TOTAL);
    localparam logic [9:0]  V_SYNC_C      = 10'(V_SYNC);
    localparam logic [9:0]  V_ACT_START_C = 10'(V_ACT_START);
    localparam logic [9:0]  V_ACT_END_C   = 10'(V_ACT_END);
    localparam logic [4:0]  LOCK_FRAMES_C = 5'(LOCK_FRAMES);

    state_t      state, state_nxt;
    logic [3:0]  good_cnt, good_nxt;
    logic [10:0] h_cnt, h_nxt;
    logic [9:0]  v_cnt, v_nxt;
    logic [9:0]  vw_cnt, vw_nxt;
    logic        hs_prev, vs_prev, vs_line_prev;
    logic        err_latch, err_latch_nxt;
    logic        hs_rise, hs_fall, vs_rise, sof, chk_en;
    logic        h_err, hw_err, v_err, vw_err, frame_err, lock_loss;
    logic        de_nxt;

    assign hs_rise = HSync & ~hs_prev;
    assign hs_fall = ~HSync & hs_prev;
    assign vs_rise = VSync & ~vs_prev;
    assign sof     = hs_rise & vs_rise;

    // Timing checks are meaningless until the counters have been aligned by a frame start.
    assign chk_en    = (state != ST_UNLOCKED);
    assign h_err     = chk_en & hs_rise & (({1'b0, h_cnt} + 12'd1) != H_TOTAL_C);
    assign hw_err    = chk_en & hs_fall & (({1'b0, h_cnt} + 12'd1) != H_SYNC_C);
    assign v_err     = chk_en & vs_rise & (~hs_rise | (({1'b0, v_cnt} + 11'd1) != V_TOTAL_C));
    assign vw_err    = chk_en & hs_rise & ~VSync & vs_line_prev & (vw_cnt != V_SYNC_C);
    assign frame_err = h_err | hw_err | v_err | vw_err;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        h_nxt  = (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;
        v_nxt  = v_cnt;
        vw_nxt = vw_cnt;
        if (hs_rise) begin
            h_nxt = '0;
            if (vs_rise)
                v_nxt = '0;
            else if (v_cnt != 10'h3FF)
                v_nxt = v_cnt + 10'd1;
            if (VSync) begin
                if (vs_rise)
                    vw_nxt = 10'd1;
                else if (vw_cnt != 10'h3FF)
                    vw_nxt = vw_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        good_nxt      = good_cnt;
        lock_loss     = 1'b0;
        err_latch_nxt = sof ? 1'b0 : (err_latch | frame_err);
        case (state)
            ST_UNLOCKED: begin
                if (sof) begin
                    state_nxt = ST_ACQUIRE;
                    good_nxt  = '0;
                end
            end
            ST_ACQUIRE: begin
                // An error seen on the closing frame_start itself vetoes lock completion.
                if (sof) begin
                    if (err_latch | frame_err) begin
                        good_nxt = '0;
                    end else begin
                        good_nxt = good_cnt + 4'd1;
                        if (({1'b0, good_cnt} + 5'd1) == LOCK_FRAMES_C)
                            state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (frame_err) begin
                    state_nxt = ST_UNLOCKED;
                    lock_loss = 1'b1;
                end
            end
            default: state_nxt = ST_UNLOCKED;
        endcase
    end

    assign de_nxt = (state_nxt == ST_LOCKED) &&
                    (h_nxt >= H_ACT_START_C) && (h_nxt < H_ACT_END_C) &&
                    (v_nxt >= V_ACT_START_C) && (v_nxt < V_ACT_END_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_UNLOCKED;
            good_cnt     <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            vw_cnt       <= '0;
            hs_prev      <= 1'b0;
            vs_prev      <= 1'b0;
            vs_line_prev <= 1'b0;
            err_latch    <= 1'b0;
            x            <= '0;
            y            <= '0;
            de           <= 1'b0;
            pix_rgb      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            err_cnt      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            line_start  <= pix_ce & hs_rise;
            frame_start <= pix_ce & sof;
            if (pix_ce) begin
                state     <= state_nxt;
                good_cnt  <= good_nxt;
                h_cnt     <= h_nxt;
                v_cnt     <= v_nxt;
                vw_cnt    <= vw_nxt;
                hs_prev   <= HSync;
                vs_prev   <= VSync;
                err_latch <= err_latch_nxt;
                if (hs_rise)
                    vs_line_prev <= VSync;
                de      <= de_nxt;
                x       <= de_nxt ? 10'(h_nxt - H_ACT_START_C) : '0;
                y       <= de_nxt ? 9'(v_nxt - V_ACT_START_C) : '0;
                pix_rgb <= {Red, Green, Blue};
                if (lock_loss && (err_cnt != 8'hFF))
                    err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign locked = (state == ST_LOCKED);

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc;

    // MSB-first CRC-16-CCITT over R, G, B in one step.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb)
                r = r ^ 16'h1021;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc       <= 16'hFFFF;
            frame_crc <= '0;
        end else if (pix_ce) begin
            if (sof) begin
                frame_crc <= crc;
                crc       <= 16'hFFFF;
            end else if (de_nxt) begin
                crc <= crc_step(crc, {Red, Green, Blue});
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a shrunken raster (40x14 samples) so many frames fit in a short run.
// Build with VGA_RX_CRC_EN defined to also exercise frame_crc.
module tb_vga_sync_decoder;

    localparam int HT  = 40;
    localparam int HS  = 6;
    localparam int HA0 = 10;
    localparam int HA1 = 34;
    localparam int VT  = 14;
    localparam int VS  = 2;
    localparam int VA0 = 3;
    localparam int VA1 = 12;
    localparam int LF  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic        HSync = 1'b0;
    logic        VSync = 1'b0;
    logic [7:0]  Red = '0, Green = '0, Blue = '0;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        de;
    logic [23:0] pix_rgb;
    logic        line_start, frame_start, locked;
    logic [7:0]  err_cnt;
`ifdef VGA_RX_CRC_EN
    logic [15:0] frame_crc;
`endif

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA0), .V_ACT_END(VA1),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .HSync(HSync), .VSync(VSync),
        .Red(Red), .Green(Green), .Blue(Blue),
        .x(x), .y(y), .de(de), .pix_rgb(pix_rgb),
        .line_start(line_start), .frame_start(frame_start),
        .locked(locked), .err_cnt(err_cnt)
`ifdef VGA_RX_CRC_EN
        , .frame_crc(frame_crc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         h;
        int         v;
        logic       exp_de;
        logic [9:0] exp_x;
        logic [8:0] exp_y;
    } probe_t;

    probe_t probes[7];

    int n_vec = 0;
    int n_bad = 0;
    int gh = 0, gv = 0;
    int mod_v = -1, mod_len = HT, mod_hsw = HS;
    bit white = 1'b0;
    bit fs_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sends one pixel sample at the current raster position, then checks the per-sample outputs.
    task automatic step();
        int          len, hsw;
        logic [23:0] rgb;
        logic        exp_ls, exp_fs;
        len    = (gv == mod_v) ? mod_len : HT;
        hsw    = (gv == mod_v) ? mod_hsw : HS;
        rgb    = white ? 24'hFFFFFF : {8'(gh), 8'(gv), 8'h5A};
        exp_ls = (gh == 0);
        exp_fs = (gh == 0) && (gv == 0);
        @(posedge clk); #1;
        HSync  = (gh < hsw);
        VSync  = (gv < VS);
        {Red, Green, Blue} = rgb;
        pix_ce = 1'b1;
        @(posedge clk); #1;
        pix_ce = 1'b0;
        check("pulses", 32'({line_start, frame_start}), 32'({exp_ls, exp_fs}));
        check("pix_rgb", 32'(pix_rgb), 32'(rgb));
        fs_seen = frame_start;
        gh++;
        if (gh >= len) begin
            gh = 0;
            if (gv == mod_v)
                mod_v = -1;
            gv = (gv + 1) % VT;
        end
    endtask

    task automatic goto_pos(input int h, input int v);
        int budget;
        budget = 3 * (HT + 1) * VT;
        while (!(gh == h && gv == v) && budget > 0) begin
            step();
            budget--;
        end
        check($sformatf("reach_h%0d_v%0d", h, v), 32'(gh == h && gv == v), 32'd1);
    endtask

    task automatic run_to_fs();
        int budget;
        budget  = 2 * (HT + 1) * VT;
        fs_seen = 1'b0;
        while (!fs_seen && budget > 0) begin
            step();
            budget--;
        end
        check("frame_start_seen", 32'(fs_seen), 32'd1);
    endtask

    task automatic relock(input string tag, input logic [7:0] exp_err);
        for (int f = 1; f <= 3; f++) begin
            run_to_fs();
            check($sformatf("%s_locked_fs%0d", tag, f), 32'(locked), 32'(f == 3));
        end
        check($sformatf("%s_err_cnt", tag), 32'(err_cnt), 32'(exp_err));
    endtask

`ifdef VGA_RX_CRC_EN
    function automatic logic [15:0] crc_ones(input int n_bytes);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n_bytes * 8; i++) begin
            fb = c[15] ^ 1'b1;
            c  = {c[14:0], 1'b0};
            if (fb)
                c = c ^ 16'h1021;
        end
        return c;
    endfunction
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        probes[0] = '{HA0,     VA0,     1'b1, 10'd0,  9'd0};
        probes[1] = '{HA1 - 1, VA1 - 1, 1'b1, 10'd23, 9'd8};
        probes[2] = '{HA1,     VA1 - 1, 1'b0, 10'd0,  9'd0};
        probes[3] = '{HA0 - 1, 5,       1'b0, 10'd0,  9'd0};
        probes[4] = '{20,      VA0 - 1, 1'b0, 10'd0,  9'd0};
        probes[5] = '{20,      VA1,     1'b0, 10'd0,  9'd0};
        probes[6] = '{20,      5,       1'b1, 10'd10, 9'd2};

        #12;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_de_x_y", 32'({de, x, y}), 32'd0);
        check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        check("rst_pulses", 32'({line_start, frame_start}), 32'd0);
        #5 rst_n = 1'b1;

        relock("acquire", 8'd0);

        foreach (probes[i]) begin
            goto_pos(probes[i].h, probes[i].v);
            step();
            check($sformatf("de_p%0d", i), 32'(de), 32'(probes[i].exp_de));
            check($sformatf("x_p%0d", i), 32'(x), 32'(probes[i].exp_x));
            check($sformatf("y_p%0d", i), 32'(y), 32'(probes[i].exp_y));
        end
        check("locked_after_probes", 32'(locked), 32'd1);

        // One line one sample too long: lock drops on the following HSync rising edge.
        goto_pos(0, 5);
        mod_v = 5; mod_len = HT + 1; mod_hsw = HS;
        goto_pos(0, 6);
        check("locked_before_long_edge", 32'(locked), 32'd1);
        step();
        check("unlock_long_line", 32'(locked), 32'd0);
        check("err_cnt_long_line", 32'(err_cnt), 32'd1);
        relock("relock1", 8'd1);

        // One line with HSync one sample short: lock drops on its falling edge.
        goto_pos(0, 7);
        mod_v = 7; mod_len = HT; mod_hsw = HS - 1;
        goto_pos(HS - 1, 7);
        check("locked_before_short_hs", 32'(locked), 32'd1);
        step();
        check("unlock_short_hs", 32'(locked), 32'd0);
        check("err_cnt_short_hs", 32'(err_cnt), 32'd2);

        // Error on the frame_start that would complete lock: acquisition restarts.
        run_to_fs();
        check("acq_fsA_locked", 32'(locked), 32'd0);
        run_to_fs();
        check("acq_fsB_locked", 32'(locked), 32'd0);
        mod_v = VT - 1; mod_len = HT + 1; mod_hsw = HS;
        run_to_fs();
        check("err_beats_lock", 32'(locked), 32'd0);
        check("err_cnt_in_acquire", 32'(err_cnt), 32'd2);
        run_to_fs();
        check("acq_fsD_locked", 32'(locked), 32'd0);
        run_to_fs();
        check("acq_fsE_locked", 32'(locked), 32'd1);

`ifdef VGA_RX_CRC_EN
        white = 1'b1;
        run_to_fs();
        check("frame_crc_white", 32'(frame_crc), 32'(crc_ones(3 * (HA1 - HA0) * (VA1 - VA0))));
        run_to_fs();
        check("frame_crc_repeat", 32'(frame_crc), 32'(crc_ones(3 * (HA1 - HA0) * (VA1 - VA0))));
        white = 1'b0;
`endif

        // Asynchronous reset in the middle of an active line while locked.
        goto_pos(20, 5);
        check("pre_reset_de", 32'(de), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_de_x_y", 32'({de, x, y}), 32'd0);
        check("midrst_pix_rgb", 32'(pix_rgb), 32'd0);
        check("midrst_pulses", 32'({line_start, frame_start}), 32'd0);
        #3 rst_n = 1'b1;
        relock("post_reset", 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
